// File: rtl/hr_mux_ctrl_pkg.sv
// Shared types and constants for the half-rate mux feed controller.
// Holds the FSM state encoding, PRBS7 polynomial/seed and default patterns.
// No logic state of its own; helpers are pure functions.
package hr_mux_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_PRBS  = 2'd2,
        ST_DATA  = 2'd3
    } state_e;

    // x^7 + x^6 + 1: feedback is bit6 ^ bit5 of the shift register
    localparam logic [6:0] PRBS7_TAPS = 7'h60;
    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    localparam logic [3:0] DEF_IDLE_PAT    = 4'b0000;
    localparam logic [3:0] DEF_TRAIN_PAT   = 4'b0101;
    localparam int         DEF_TRAIN_WORDS = 64;
    localparam int         DEF_UFLOW_W     = 8;

    function automatic logic [6:0] prbs7_step(input logic [6:0] s);
        return {s[5:0], ^(s & PRBS7_TAPS)};
    endfunction

    // Serial bit k (taken from bit 6) lands on word bit k
    function automatic logic [3:0] prbs7_word(input logic [6:0] s);
        logic [6:0] t;
        logic [3:0] w;
        t = s;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            w[k] = t[6];
            t    = prbs7_step(t);
        end
        return w;
    endfunction

    function automatic logic [6:0] prbs7_adv4(input logic [6:0] s);
        logic [6:0] t;
        t = s;
        for (int k = 0; k < 4; k++) begin
            t = prbs7_step(t);
        end
        return t;
    endfunction

endpackage

// File: rtl/hr_mux_feed_ctrl_prbs7_par4.sv
// PRBS7 generator producing four serial bits per clock as a parallel word.
// Latency: word is combinational from the current LFSR state; state advances on adv.
// No backpressure: load reseeds (priority over adv), adv steps 4 bits.
module prbs7_par4
    import hr_mux_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       adv,
    output logic [3:0] word
);

    logic [6:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= PRBS7_SEED;
        end else if (load) begin
            lfsr <= PRBS7_SEED;
        end else if (adv) begin
            lfsr <= prbs7_adv4(lfsr);
        end
    end

    assign word = prbs7_word(lfsr);

endmodule

// File: rtl/hr_mux_feed_ctrl.sv
// Source sequencer/arbiter for the 4-bit half-rate serializer feed; HR_MUX_ERR_INJ_EN adds error injection.
// Latency: the word selected in a cycle appears on dout_o one cycle later.
// Backpressure: data_ready_o is high only in DATA; a missing data_valid_i sends IDLE_PAT and counts an underflow.
module hr_mux_feed_ctrl
    import hr_mux_ctrl_pkg::*;
#(
    parameter int         TRAIN_WORDS = DEF_TRAIN_WORDS,
    parameter logic [3:0] IDLE_PAT    = DEF_IDLE_PAT,
    parameter logic [3:0] TRAIN_PAT   = DEF_TRAIN_PAT,
    parameter int         UFLOW_W     = DEF_UFLOW_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               sel_prbs_i,
    input  logic [3:0]         data_i,
    input  logic               data_valid_i,
    output logic               data_ready_o,
    output logic [3:0]         dout_o,
    output logic [1:0]         state_o,
    output logic               train_done_o,
`ifdef HR_MUX_ERR_INJ_EN
    input  logic               err_inj_i,
    input  logic [1:0]         err_bit_i,
    output logic [7:0]         err_inj_cnt_o,
`endif
    output logic [UFLOW_W-1:0] uflow_cnt_o
);

    localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_WORDS - 1);

    state_e      state;
    state_e      state_nxt;
    logic [15:0] train_cnt;
    logic        train_last;
    logic [3:0]  word_sel;
    logic [3:0]  word_out;
    logic [3:0]  prbs_word;
    logic        prbs_load;
    logic        prbs_adv;
    logic        uflow_inc;
    logic        enter_train;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign train_last = (state == ST_TRAIN) && (train_cnt == TRAIN_LAST);

    // Next-state logic; stop_i overrides every other transition
    always_comb begin
        state_nxt = state;
        if (stop_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start_i) state_nxt = ST_TRAIN;
                ST_TRAIN: if (train_last) state_nxt = sel_prbs_i ? ST_PRBS : ST_DATA;
                default:  state_nxt = state;
            endcase
        end
    end

    // Output/control decode
    always_comb begin
        word_sel     = IDLE_PAT;
        prbs_adv     = 1'b0;
        uflow_inc    = 1'b0;
        data_ready_o = 1'b0;
        case (state)
            ST_TRAIN: word_sel = TRAIN_PAT;
            ST_PRBS: begin
                word_sel = prbs_word;
                prbs_adv = 1'b1;
            end
            ST_DATA: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    word_sel = data_i;
                end else begin
                    uflow_inc = 1'b1;
                end
            end
            default: word_sel = IDLE_PAT;
        endcase
        prbs_load   = (state != ST_PRBS) && (state_nxt == ST_PRBS);
        enter_train = (state != ST_TRAIN) && (state_nxt == ST_TRAIN);
    end

    prbs7_par4 u_prbs (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (prbs_load),
        .adv   (prbs_adv),
        .word  (prbs_word)
    );

`ifdef HR_MUX_ERR_INJ_EN
    logic err_hit;

    assign err_hit  = err_inj_i && ((state == ST_PRBS) || (state == ST_DATA));
    assign word_out = err_hit ? (word_sel ^ (4'b0001 << err_bit_i)) : word_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_inj_cnt_o <= '0;
        end else if (err_hit && (err_inj_cnt_o != 8'hFF)) begin
            err_inj_cnt_o <= err_inj_cnt_o + 8'd1;
        end
    end
`else
    assign word_out = word_sel;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_o       <= IDLE_PAT;
            train_cnt    <= '0;
            train_done_o <= 1'b0;
            uflow_cnt_o  <= '0;
        end else begin
            dout_o       <= word_out;
            train_cnt    <= ((state == ST_TRAIN) && (state_nxt == ST_TRAIN)) ? train_cnt + 16'd1 : 16'd0;
            train_done_o <= train_last && !stop_i;
            if (enter_train) begin
                uflow_cnt_o <= '0;
            end else if (uflow_inc && (uflow_cnt_o != {UFLOW_W{1'b1}})) begin
                uflow_cnt_o <= uflow_cnt_o + UFLOW_W'(1);
            end
        end
    end

    assign state_o = state;

endmodule
